osf_stream_packer: RTL

//  Multi-channel successor to the single focused-channel bulk path. Captures oversample-filter samples from all

---
 rtl/osf_stream_packer_pkg.sv | 11 +
 rtl/osf_stream_packer_if.sv | 8 +
 rtl/osf_stream_packer_rr_arbiter.sv | 22 ++
 rtl/osf_stream_packer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/osf_stream_packer_pkg.sv
// osf_stream_pkg: FSM encoding and header field positions shared by the stream packer
package osf_stream_pkg;
    typedef enum logic [1:0] {IDLE, HDR, DAT} state_t;
    localparam int HDR_MARK     = 15;
    localparam int HDR_OVF      = 14;
    localparam int HDR_SEQ_LSB  = 4;
    localparam int HDR_CHAN_LSB = 0;
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/osf_stream_packer_if.sv
// osf_stream_packer_if: valid/ready word stream toward the pipe tx FIFO
interface osf_stream_packer_if #(parameter int W_EP = 16);
    logic [W_EP-1:0] word;
    logic            word_valid;
    logic            word_ready;
    modport master(output word, word_valid, input word_ready);
    modport slave(input word, word_valid, output word_ready);
endinterface

// File: rtl/osf_stream_packer_rr_arbiter.sv
// rr_arbiter: picks the first requesting channel at or after ptr, wrapping to 0
module rr_arbiter #(
    parameter int N     = 8,
    parameter int W_IDX = 3
) (
    input  logic [N-1:0]     req,
    input  logic [W_IDX-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [W_IDX-1:0] idx
);
    always_comb begin
        gnt = '0;
        idx = '0;
        // scan from the far end so the closest request to ptr is written last
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                gnt = N'(1) << ((int'(ptr) + i) % N);
                idx = W_IDX'((int'(ptr) + i) % N);
            end
        end
    end
endmodule

// File: rtl/osf_stream_packer.sv
// osf_stream_packer: captures decimated samples from masked osf channels and
// serialises each one as a tagged header/data word pair on a valid/ready stream
module osf_stream_packer
    import osf_stream_pkg::*;
#(
    parameter int N_ADC      = 8,
    parameter int W_ADC_DATA = 18,
    parameter int W_EP       = 16,
    parameter int W_DEC      = 8,
    parameter int W_SEQ      = 10
) (
    input  logic                        clk50_in,
    input  logic                        sys_reset_in,
    input  logic [N_ADC-1:0]            osf_data_valid_in,
    input  logic [N_ADC*W_ADC_DATA-1:0] osf_data_packed_in,
    input  logic [N_ADC-1:0]            cfg_chan_mask_in,
    input  logic [W_DEC-1:0]            cfg_decim_in,
    input  logic                        cfg_update_in,
    osf_stream_packer_if.master         word_if,
    output logic [15:0]                 drop_count_out,
    output logic                        busy_out
);
    localparam int W_IDX = idx_width(N_ADC);
    state_t            state;
    logic [N_ADC-1:0]  mask_q, mask_stg, pending, ovf, accept, req_gnt, grant, ovf_new;
    logic [W_DEC-1:0]  decim_q, decim_stg;
    logic              upd_pend, flush;
    logic [W_DEC-1:0]  dcnt [N_ADC];
    logic [W_EP-1:0]   hold [N_ADC];
    logic [W_SEQ-1:0]  seq [N_ADC];
    logic [W_IDX-1:0]  rr_ptr, gnt_idx;
    logic [W_EP-1:0]   dat_word;
    logic [16:0]       drop_sum;

    function automatic logic [W_EP-1:0] hdr_word(input logic o, input logic [W_SEQ-1:0] s,
                                                 input logic [W_IDX-1:0] c);
        logic [W_EP-1:0] h;
        h = '0;
        h[HDR_MARK] = 1'b1;
        h[HDR_OVF] = o;
        h[HDR_SEQ_LSB +: W_EP - 6] = s[W_EP-7:0];
        h[HDR_CHAN_LSB +: 4] = 4'(c);
        return h;
    endfunction

    rr_arbiter #(.N(N_ADC), .W_IDX(W_IDX)) u_arb (
        .req(pending), .ptr(rr_ptr), .gnt(req_gnt), .idx(gnt_idx)
    );

    // a config update only lands between word pairs, and wins over a grant that cycle
    always_comb begin
        flush = (state == IDLE) && (cfg_update_in || upd_pend);
        grant = (state == IDLE && !flush) ? req_gnt : '0;
        accept = '0;
        for (int c = 0; c < N_ADC; c++)
            accept[c] = osf_data_valid_in[c] && mask_q[c] && dcnt[c] == '0;
        ovf_new = accept & pending & ~grant;
        drop_sum = {1'b0, drop_count_out} + 17'($countones(ovf_new));
    end

    assign busy_out = |pending || state != IDLE;

    always_ff @(posedge clk50_in) begin
        if (sys_reset_in) begin
            state <= IDLE;
            mask_q <= '0;
            mask_stg <= '0;
            decim_q <= '0;
            decim_stg <= '0;
            upd_pend <= 1'b0;
            pending <= '0;
            ovf <= '0;
            rr_ptr <= '0;
            drop_count_out <= '0;
            dat_word <= '0;
            word_if.word <= '0;
            word_if.word_valid <= 1'b0;
            for (int c = 0; c < N_ADC; c++) begin
                dcnt[c] <= '0;
                hold[c] <= '0;
                seq[c] <= '0;
            end
        end else begin
            if (cfg_update_in) begin
                mask_stg <= cfg_chan_mask_in;
                decim_stg <= cfg_decim_in;
            end
            if (flush) begin
                mask_q <= cfg_update_in ? cfg_chan_mask_in : mask_stg;
                decim_q <= cfg_update_in ? cfg_decim_in : decim_stg;
                upd_pend <= 1'b0;
                pending <= '0;
                ovf <= '0;
                rr_ptr <= '0;
                for (int c = 0; c < N_ADC; c++) begin
                    dcnt[c] <= '0;
                    hold[c] <= '0;
                    seq[c] <= '0;
                end
            end else begin
                upd_pend <= upd_pend || cfg_update_in;
                pending <= (pending & ~grant) | accept;
                ovf <= (ovf & ~grant) | ovf_new;
                drop_count_out <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
                if (|grant)
                    rr_ptr <= (int'(gnt_idx) == N_ADC - 1) ? '0 : gnt_idx + 1'b1;
                for (int c = 0; c < N_ADC; c++) begin
                    if (osf_data_valid_in[c] && mask_q[c])
                        dcnt[c] <= (dcnt[c] == decim_q) ? '0 : dcnt[c] + 1'b1;
                    if (accept[c])
                        hold[c] <= osf_data_packed_in[c*W_ADC_DATA + W_ADC_DATA - W_EP +: W_EP];
                    if (grant[c])
                        seq[c] <= seq[c] + 1'b1;
                end
            end
            case (state)
                IDLE: if (|grant) begin
                    word_if.word <= hdr_word(ovf[gnt_idx], seq[gnt_idx], gnt_idx);
                    word_if.word_valid <= 1'b1;
                    dat_word <= hold[gnt_idx];
                    state <= HDR;
                end
                HDR: if (word_if.word_ready) begin
                    word_if.word <= dat_word;
                    state <= DAT;
                end
                DAT: if (word_if.word_ready) begin
                    word_if.word_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
